// File: rtl/vt_pkg.sv
// vt_pkg: shared VT100 constants, special-key indices, FSM state encoding and
// byte helpers used by the key encoder (and the receive-side escape parser).
// No ports; import with "import vt_pkg::*".
package vt_pkg;

  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CSI   = 8'h5B;  // '['
  localparam logic [7:0] CH_TILDE = 8'h7E;  // '~'

  localparam logic [3:0] KEY_UP    = 4'd0;
  localparam logic [3:0] KEY_DOWN  = 4'd1;
  localparam logic [3:0] KEY_RIGHT = 4'd2;
  localparam logic [3:0] KEY_LEFT  = 4'd3;
  localparam logic [3:0] KEY_HOME  = 4'd4;
  localparam logic [3:0] KEY_END   = 4'd5;
  localparam logic [3:0] KEY_INS   = 4'd6;
  localparam logic [3:0] KEY_DEL   = 4'd7;
  localparam logic [3:0] KEY_PGUP  = 4'd8;
  localparam logic [3:0] KEY_PGDN  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ESC   = 3'd1,
    ST_CSI   = 3'd2,
    ST_PARAM = 3'd3,
    ST_FINAL = 3'd4,
    ST_LF    = 3'd5
  } vt_state_e;

  // One queued key event: code[8]=1 selects a special key index in code[3:0].
  typedef struct packed {
    logic       ctrl;
    logic [8:0] code;
  } key_entry_t;

  localparam int KEY_W = $bits(key_entry_t);

  function automatic logic is_param_key(input logic [3:0] idx);
    is_param_key = (idx >= KEY_INS) && (idx <= KEY_PGDN);
  endfunction

  function automatic logic is_enter(input key_entry_t k);
    is_enter = !k.code[8] && ((k.code[7:0] == CH_CR) || (k.code[7:0] == CH_LF));
  endfunction

  // First state of the sequence for an entry; IDLE means the entry is dropped.
  function automatic vt_state_e first_state(input key_entry_t k);
    if (!k.code[8]) begin
      first_state = ST_FINAL;
    end else if (k.code[3:0] <= KEY_PGDN) begin
      first_state = ST_ESC;
    end else begin
      first_state = ST_IDLE;
    end
  endfunction

  function automatic logic [7:0] param_byte(input logic [3:0] idx);
    case (idx)
      KEY_INS:  param_byte = 8'h32;
      KEY_DEL:  param_byte = 8'h33;
      KEY_PGUP: param_byte = 8'h35;
      KEY_PGDN: param_byte = 8'h36;
      default:  param_byte = 8'h00;
    endcase
  endfunction

  // Last byte of a special sequence, or the translated byte of an ASCII key.
  function automatic logic [7:0] final_byte(input key_entry_t k);
    logic [7:0] b;
    b = k.code[7:0];
    if (k.code[8]) begin
      case (k.code[3:0])
        KEY_UP:    final_byte = 8'h41;
        KEY_DOWN:  final_byte = 8'h42;
        KEY_RIGHT: final_byte = 8'h43;
        KEY_LEFT:  final_byte = 8'h44;
        KEY_HOME:  final_byte = 8'h48;
        KEY_END:   final_byte = 8'h46;
        KEY_INS, KEY_DEL, KEY_PGUP, KEY_PGDN: final_byte = CH_TILDE;
        default:   final_byte = 8'h00;
      endcase
    end else if ((b == CH_CR) || (b == CH_LF)) begin
      final_byte = CH_CR;
    end else if (k.ctrl && (b[7:6] == 2'b01)) begin
      // Ctrl only folds 0x40..0x7F onto the C0 control range.
      final_byte = b & 8'h1F;
    end else begin
      final_byte = b;
    end
  endfunction

endpackage

// File: rtl/vt_key_encoder_if.sv
// vt_key_encoder_if: key-event input handshake, UART byte output handshake and
// the overflow flag of the key encoder.
//   slave  : encoder side (takes key events, produces tx bytes)
//   master : key source / transmitter side
interface vt_key_encoder_if;
  logic       key_valid;
  logic [8:0] key_code;
  logic       key_ctrl;
  logic       key_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       overflow;

  modport master (
    output key_valid, key_code, key_ctrl, tx_ready,
    input  key_ready, tx_data, tx_valid, overflow
  );

  modport slave (
    input  key_valid, key_code, key_ctrl, tx_ready,
    output key_ready, tx_data, tx_valid, overflow
  );
endinterface

// File: rtl/key_fifo.sv
// key_fifo: synchronous FIFO, power-of-two DEPTH, WIDTH-bit entries.
// Ports: clk, rst (async high), push/din, pop/dout (show-ahead), full, empty.
// Pushes while full and pops while empty are ignored.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  // The extra MSB distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        wr_en_s;
  logic        rd_en_s;

  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign wr_en_s = push && !full;
  assign rd_en_s = pop && !empty;
  assign dout    = mem[rd_ptr_r[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/vt_key_encoder.sv
// vt_key_encoder: turns keyboard events into VT100 byte streams for a UART.
// Ports: clk100, rst (async high), bus (slave modport of vt_key_encoder_if:
// key_valid/key_code/key_ctrl/key_ready in, tx_data/tx_valid/tx_ready out,
// sticky overflow). Events are queued in key_fifo; the FSM pops one entry and
// emits its byte sequence back-to-back on the tx handshake.
module vt_key_encoder
  import vt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit ENTER_CRLF = 1'b0
) (
  input  logic               clk100,
  input  logic               rst,
  vt_key_encoder_if.slave    bus
);

  logic       key_ready_s;
  logic       push_s;
  logic       pop_s;
  logic       advance_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  key_entry_t fifo_din_s;
  key_entry_t fifo_dout_s;

  vt_state_e  state_r;
  vt_state_e  state_nxt_s;
  key_entry_t key_r;
  key_entry_t key_nxt_s;
  logic [7:0] tx_data_r;
  logic [7:0] tx_data_nxt_s;
  logic       tx_valid_r;
  logic       tx_valid_nxt_s;
  logic       overflow_r;

  // key_ready drops with rst directly so nothing is offered as accepted in reset.
  assign key_ready_s = !fifo_full_s && !rst;
  assign push_s      = bus.key_valid && key_ready_s;
  assign fifo_din_s  = {bus.key_ctrl, bus.key_code};
  // The presented byte may be replaced when nothing is presented or it is taken.
  assign advance_s   = !tx_valid_r || bus.tx_ready;

  assign bus.key_ready = key_ready_s;
  assign bus.tx_data   = tx_data_r;
  assign bus.tx_valid  = tx_valid_r;
  assign bus.overflow  = overflow_r;

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_key_fifo (
    .clk   (clk100),
    .rst   (rst),
    .push  (push_s),
    .din   (fifo_din_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // State, current key and registered tx outputs.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      key_r      <= '0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      key_r      <= key_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      tx_valid_r <= tx_valid_nxt_s;
    end
  end

  // Sticky overflow: a key offered while the encoder cannot take it.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (bus.key_valid && !key_ready_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Next state; state names the byte presented on tx_data. Leaving the last
  // byte of a sequence pops the next entry on the same edge (no idle gap).
  always_comb begin
    state_nxt_s = state_r;
    key_nxt_s   = key_r;
    pop_s       = 1'b0;
    if (advance_s) begin
      case (state_r)
        ST_ESC: begin
          state_nxt_s = ST_CSI;
        end
        ST_CSI: begin
          if (is_param_key(key_r.code[3:0])) begin
            state_nxt_s = ST_PARAM;
          end else begin
            state_nxt_s = ST_FINAL;
          end
        end
        ST_PARAM: begin
          state_nxt_s = ST_FINAL;
        end
        ST_IDLE, ST_FINAL, ST_LF: begin
          if ((state_r == ST_FINAL) && ENTER_CRLF && is_enter(key_r)) begin
            state_nxt_s = ST_LF;
          end else if (!fifo_empty_s) begin
            // Dropped special indices decode to IDLE: popped, nothing sent.
            pop_s       = 1'b1;
            key_nxt_s   = fifo_dout_s;
            state_nxt_s = first_state(fifo_dout_s);
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Byte to present after the edge; a stall keeps state and key, so the byte holds.
  always_comb begin
    tx_data_nxt_s  = 8'h00;
    tx_valid_nxt_s = 1'b1;
    case (state_nxt_s)
      ST_ESC:   tx_data_nxt_s = CH_ESC;
      ST_CSI:   tx_data_nxt_s = CH_CSI;
      ST_PARAM: tx_data_nxt_s = param_byte(key_nxt_s.code[3:0]);
      ST_FINAL: tx_data_nxt_s = final_byte(key_nxt_s);
      ST_LF:    tx_data_nxt_s = CH_LF;
      ST_IDLE: begin
        tx_data_nxt_s  = 8'h00;
        tx_valid_nxt_s = 1'b0;
      end
      default: begin
        tx_data_nxt_s  = 8'h00;
        tx_valid_nxt_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vt_key_encoder.sv
// tb_vt_key_encoder: self-checking bench for vt_key_encoder (FIFO_DEPTH=4,
// ENTER_CRLF=1). A byte-queue reference model expands each accepted key into
// its VT100 bytes; every tx handshake is compared against it.
module tb_vt_key_encoder;

  localparam int DEPTH = 4;
  localparam bit CRLF  = 1'b1;

  logic clk100 = 1'b0;
  logic rst;

  always #5 clk100 = ~clk100;

  vt_key_encoder_if bus_if ();

  vt_key_encoder #(
    .FIFO_DEPTH (DEPTH),
    .ENTER_CRLF (CRLF)
  ) dut (
    .clk100 (clk100),
    .rst    (rst),
    .bus    (bus_if)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q [$];
  logic        model_ovf;
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic [7:0]  arrow_tbl [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h46};
  logic [7:0]  param_tbl [4] = '{8'h32, 8'h33, 8'h35, 8'h36};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the byte sequence a key event must produce.
  task automatic model_key(input logic ctrl, input logic [8:0] code);
    int         idx;
    logic [7:0] b;
    if (code[8]) begin
      idx = int'(code[3:0]);
      if (idx < 6) begin
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h5B);
        exp_q.push_back(arrow_tbl[idx]);
      end else if (idx < 10) begin
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h5B);
        exp_q.push_back(param_tbl[idx - 6]);
        exp_q.push_back(8'h7E);
      end
    end else begin
      b = code[7:0];
      if (b == 8'h0D || b == 8'h0A) begin
        exp_q.push_back(8'h0D);
        if (CRLF) exp_q.push_back(8'h0A);
      end else if (ctrl && b >= 8'h40 && b <= 8'h7F) begin
        exp_q.push_back(b & 8'h1F);
      end else begin
        exp_q.push_back(b);
      end
    end
  endtask

  // Called 1 time unit after a rising edge with inputs already set: checks,
  // records the handshakes the next edge will see, then advances one cycle.
  task automatic step();
    logic       acc;
    logic       hs;
    logic [7:0] exp_b;
    check("overflow", 32'(bus_if.overflow), 32'(model_ovf));
    if (prev_stall) begin
      check("stall_valid", 32'(bus_if.tx_valid), 32'd1);
      check("stall_data", 32'(bus_if.tx_data), 32'(prev_data));
    end
    acc = bus_if.key_valid && bus_if.key_ready;
    hs  = bus_if.tx_valid && bus_if.tx_ready;
    if (bus_if.key_valid && !bus_if.key_ready) model_ovf = 1'b1;
    if (acc) model_key(bus_if.key_ctrl, bus_if.key_code);
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("extra_byte", 32'(bus_if.tx_data), 32'h100);
      end else begin
        exp_b = exp_q.pop_front();
        check("tx_byte", 32'(bus_if.tx_data), 32'(exp_b));
      end
    end
    prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
    prev_data  = bus_if.tx_data;
    @(posedge clk100);
    #1;
  endtask

  // One key with tx_ready high: bytes must appear on nbytes consecutive cycles.
  task automatic seq_test(input string tag, input logic ctrl, input logic [8:0] code, input int nbytes);
    bus_if.tx_ready  = 1'b1;
    bus_if.key_valid = 1'b1;
    bus_if.key_ctrl  = ctrl;
    bus_if.key_code  = code;
    step();
    bus_if.key_valid = 1'b0;
    step();
    for (int i = 0; i < nbytes; i++) begin
      check(tag, 32'(bus_if.tx_valid), 32'd1);
      step();
    end
    check({tag, "_end"}, 32'(bus_if.tx_valid), 32'd0);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [8:0] rand_code();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return {1'b1, 8'($urandom_range(0, 255))};
    if (r == 3) return ($urandom_range(0, 1) != 0) ? 9'h00D : 9'h00A;
    return {1'b0, 8'($urandom_range(0, 255))};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int n;
    rst              = 1'b1;
    bus_if.key_valid = 1'b0;
    bus_if.key_code  = 9'h000;
    bus_if.key_ctrl  = 1'b0;
    bus_if.tx_ready  = 1'b1;
    model_ovf        = 1'b0;
    prev_stall       = 1'b0;
    prev_data        = 8'h00;
    repeat (2) @(posedge clk100);
    #1;
    check("rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus_if.tx_data), 32'h00);
    check("rst_key_ready", 32'(bus_if.key_ready), 32'd0);
    check("rst_overflow", 32'(bus_if.overflow), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_key_ready", 32'(bus_if.key_ready), 32'd1);

    // Latency from accept edge: low after it, high (0x61) at the 2nd edge.
    bus_if.key_valid = 1'b1;
    bus_if.key_code  = 9'h061;
    step();
    bus_if.key_valid = 1'b0;
    check("lat_accept_edge", 32'(bus_if.tx_valid), 32'd0);
    step();
    check("lat_2nd_edge", 32'(bus_if.tx_valid), 32'd1);
    check("lat_data", 32'(bus_if.tx_data), 32'h61);
    step();
    check("lat_single", 32'(bus_if.tx_valid), 32'd0);

    seq_test("up",      1'b0, 9'h100, 3);
    seq_test("end",     1'b0, 9'h105, 3);
    seq_test("insert",  1'b0, 9'h106, 4);
    seq_test("delete",  1'b0, 9'h107, 4);
    seq_test("pgup",    1'b0, 9'h108, 4);
    seq_test("pgdn",    1'b1, 9'h109, 4);
    seq_test("ctrl_c",  1'b1, 9'h063, 1);
    seq_test("ctrl_1",  1'b1, 9'h031, 1);
    seq_test("enter",   1'b0, 9'h00D, 2);
    seq_test("lf",      1'b1, 9'h00A, 2);
    seq_test("drop_12", 1'b0, 9'h10C, 0);
    seq_test("drop_15", 1'b0, 9'h10F, 0);

    // Overflow: stalled output, 5 accepted, 6th refused.
    bus_if.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_if.key_valid = 1'b1;
      bus_if.key_ctrl  = 1'b0;
      bus_if.key_code  = {1'b0, 8'(8'h30 + i)};
      if (i == 5) check("ovf_full_ready", 32'(bus_if.key_ready), 32'd0);
      step();
    end
    bus_if.key_valid = 1'b0;
    step();
    check("ovf_flag", 32'(bus_if.overflow), 32'd1);
    check("ovf_accepted", 32'(exp_q.size()), 32'd5);
    bus_if.tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("ovf_burst", 32'(bus_if.tx_valid), 32'd1);
      step();
    end
    check("ovf_burst_end", 32'(bus_if.tx_valid), 32'd0);
    check("ovf_sticky", 32'(bus_if.overflow), 32'd1);

    // Reset after ESC of a Delete sequence, with another key still queued.
    bus_if.tx_ready  = 1'b0;
    bus_if.key_valid = 1'b1;
    bus_if.key_code  = 9'h107;
    step();
    bus_if.key_code  = 9'h078;
    step();
    bus_if.key_valid = 1'b0;
    check("rst_mid_esc", 32'(bus_if.tx_data), 32'h1B);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(bus_if.tx_valid), 32'd0);
    check("rst_mid_data", 32'(bus_if.tx_data), 32'h00);
    check("rst_mid_ready", 32'(bus_if.key_ready), 32'd0);
    check("rst_mid_ovf", 32'(bus_if.overflow), 32'd0);
    exp_q.delete();
    model_ovf  = 1'b0;
    prev_stall = 1'b0;
    @(posedge clk100);
    #1;
    rst             = 1'b0;
    bus_if.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("post_rst_quiet", 32'(bus_if.tx_valid), 32'd0);
      step();
    end

    // Random keys with random tx back-pressure.
    sent = 0;
    for (int cyc = 0; cyc < 5000 && sent < 200; cyc++) begin
      if (bus_if.key_ready && ($urandom_range(0, 3) != 0)) begin
        bus_if.key_valid = 1'b1;
        bus_if.key_ctrl  = ($urandom_range(0, 1) != 0);
        bus_if.key_code  = rand_code();
        sent++;
      end else begin
        bus_if.key_valid = 1'b0;
      end
      bus_if.tx_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    check("rand_sent", 32'(sent), 32'd200);
    bus_if.key_valid = 1'b0;
    bus_if.tx_ready  = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    step();
    step();
    check("rand_idle", 32'(bus_if.tx_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
